// File: rtl/rs_syndrome_ctrl_if.sv
// Stream interface for the RS(7,5) syndrome controller: symbol input
// handshake on one side, syndrome result handshake on the other.
interface rs_syndrome_ctrl_if #(
   parameter int SYMBOL_WIDTH = 3
);
   logic                    in_valid;
   logic                    in_ready;
   logic [SYMBOL_WIDTH-1:0] in_symbol;
   logic                    in_last;
   logic                    syn_valid;
   logic                    syn_ready;
   logic [SYMBOL_WIDTH-1:0] syn1;
   logic [SYMBOL_WIDTH-1:0] syn2;
   logic                    syn_zero;
   logic                    frame_err;

   // The master is the environment (symbol source plus syndrome consumer).
   modport master (
      output in_valid, in_symbol, in_last, syn_ready,
      input  in_ready, syn_valid, syn1, syn2, syn_zero, frame_err
   );

   modport slave (
      input  in_valid, in_symbol, in_last, syn_ready,
      output in_ready, syn_valid, syn1, syn2, syn_zero, frame_err
   );
endinterface

// File: rtl/rs_syndrome_ctrl.sv
// RS(7,5) over GF(8) syndrome front end: Horner evaluation of S1 = r(alpha)
// and S2 = r(alpha^2) over a 7-symbol frame, held behind a valid/ready output.
module rs_syndrome_ctrl #(
   parameter int SYMBOL_WIDTH = 3,
   parameter int N            = 7
) (
   input logic             clk,
   input logic             rst_n,
   rs_syndrome_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(N);

   typedef enum logic {
      ACC,
      OUT
   } state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [SYMBOL_WIDTH-1:0] acc1;
   logic [SYMBOL_WIDTH-1:0] acc2;
   logic                    err;

   logic                    in_ready_r;
   logic                    syn_valid_r;
   logic [SYMBOL_WIDTH-1:0] syn1_r;
   logic [SYMBOL_WIDTH-1:0] syn2_r;
   logic                    syn_zero_r;
   logic                    frame_err_r;

   logic                    accept;
   logic                    frame_end;
   logic [SYMBOL_WIDTH-1:0] acc1_nxt;
   logic [SYMBOL_WIDTH-1:0] acc2_nxt;
   logic                    err_nxt;

   // Index form: 0 is the zero element, k is alpha^(k-1); the -1/+1 keeps x=7 from wrapping to 0.
   function automatic logic [SYMBOL_WIDTH-1:0] gf_mul_const(
      input logic [SYMBOL_WIDTH-1:0] x,
      input int unsigned             j
   );
      int unsigned e;
      if (x == '0) return '0;
      e = (32'(x) + j - 32'd1) % 32'(N);
      return SYMBOL_WIDTH'(e + 32'd1);
   endfunction

   function automatic logic [SYMBOL_WIDTH-1:0] to_poly(input logic [SYMBOL_WIDTH-1:0] x);
      logic [SYMBOL_WIDTH-1:0] p;
      case (x)
         3'd1:    p = 3'b001;
         3'd2:    p = 3'b010;
         3'd3:    p = 3'b100;
         3'd4:    p = 3'b011;
         3'd5:    p = 3'b110;
         3'd6:    p = 3'b111;
         3'd7:    p = 3'b101;
         default: p = 3'b000;
      endcase
      return p;
   endfunction

   function automatic logic [SYMBOL_WIDTH-1:0] from_poly(input logic [SYMBOL_WIDTH-1:0] p);
      logic [SYMBOL_WIDTH-1:0] x;
      case (p)
         3'b001:  x = 3'd1;
         3'b010:  x = 3'd2;
         3'b100:  x = 3'd3;
         3'b011:  x = 3'd4;
         3'b110:  x = 3'd5;
         3'b111:  x = 3'd6;
         3'b101:  x = 3'd7;
         default: x = 3'd0;
      endcase
      return x;
   endfunction

   function automatic logic [SYMBOL_WIDTH-1:0] gf_add(
      input logic [SYMBOL_WIDTH-1:0] a,
      input logic [SYMBOL_WIDTH-1:0] b
   );
      return from_poly(to_poly(a) ^ to_poly(b));
   endfunction

   assign accept    = bus.in_valid && (state == ACC);
   assign frame_end = accept && (cnt == CNT_W'(N - 1));
   assign acc1_nxt  = gf_add(gf_mul_const(acc1, 1), bus.in_symbol);
   assign acc2_nxt  = gf_add(gf_mul_const(acc2, 2), bus.in_symbol);
   assign err_nxt   = err | (bus.in_last != (cnt == CNT_W'(N - 1)));

   // The frame length is fixed at N accepts; in_last only feeds the error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ACC;
         cnt         <= '0;
         acc1        <= '0;
         acc2        <= '0;
         err         <= 1'b0;
         in_ready_r  <= 1'b1;
         syn_valid_r <= 1'b0;
         syn1_r      <= '0;
         syn2_r      <= '0;
         syn_zero_r  <= 1'b1;
         frame_err_r <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (accept) begin
                  acc1 <= acc1_nxt;
                  acc2 <= acc2_nxt;
                  err  <= err_nxt;
                  cnt  <= cnt + CNT_W'(1);
                  if (frame_end) begin
                     state       <= OUT;
                     cnt         <= '0;
                     in_ready_r  <= 1'b0;
                     syn_valid_r <= 1'b1;
                     syn1_r      <= acc1_nxt;
                     syn2_r      <= acc2_nxt;
                     syn_zero_r  <= (acc1_nxt == '0) && (acc2_nxt == '0);
                     frame_err_r <= err_nxt;
                  end
               end
            end
            OUT: begin
               if (bus.syn_ready) begin
                  state       <= ACC;
                  cnt         <= '0;
                  acc1        <= '0;
                  acc2        <= '0;
                  err         <= 1'b0;
                  in_ready_r  <= 1'b1;
                  syn_valid_r <= 1'b0;
               end
            end
            default: begin
               state <= ACC;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.syn_valid = syn_valid_r;
   assign bus.syn1      = syn1_r;
   assign bus.syn2      = syn2_r;
   assign bus.syn_zero  = syn_zero_r;
   assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// Testbench for rs_syndrome_ctrl: table of frames plus hand-built corner
// sequences, expected syndromes queued at drive time and popped at output.
module tb_rs_syndrome_ctrl;

   logic clk;
   logic rst_n;

   rs_syndrome_ctrl_if #(.SYMBOL_WIDTH(3)) bus ();

   rs_syndrome_ctrl #(
      .SYMBOL_WIDTH(3),
      .N(7)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [6:0][2:0] sym;
      logic [6:0]      last_mask;
      bit              gaps;
      bit              use_model;
      logic [2:0]      e1;
      logic [2:0]      e2;
      logic            ez;
      logic            ee;
   } vec_t;

   typedef struct packed {
      logic [2:0] s1;
      logic [2:0] s2;
      logic       z;
      logic       e;
   } exp_t;

   localparam logic [6:0] LAST_OK = 7'b1000000;

   exp_t exp_q[$];
   vec_t tbl[12];
   int   checks = 0;
   int   passes = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model works in power basis with shift-and-reduce by x^3+x+1.
   function automatic logic [2:0] poly_of(input logic [2:0] k);
      logic [2:0] p;
      p = 3'b001;
      if (k == 3'd0) return 3'b000;
      for (int i = 1; i < int'(k); i++) p = {p[1:0], 1'b0} ^ (p[2] ? 3'b011 : 3'b000);
      return p;
   endfunction

   function automatic logic [2:0] index_of(input logic [2:0] p);
      for (int k = 0; k < 8; k++) if (poly_of(3'(k)) == p) return 3'(k);
      return 3'd0;
   endfunction

   function automatic logic [2:0] model_syn(input logic [6:0][2:0] sym, input int j);
      logic [2:0] sum;
      logic [2:0] p;
      sum = 3'b000;
      for (int k = 0; k < 7; k++) begin
         p = poly_of(sym[k]);
         for (int s = 0; s < (6 - k) * j; s++) p = {p[1:0], 1'b0} ^ (p[2] ? 3'b011 : 3'b000);
         sum = sum ^ p;
      end
      return index_of(sum);
   endfunction

   function automatic logic [6:0][2:0] frame7(
      input logic [2:0] r6, r5, r4, r3, r2, r1, r0
   );
      logic [6:0][2:0] f;
      f[0] = r6; f[1] = r5; f[2] = r4; f[3] = r3; f[4] = r2; f[5] = r1; f[6] = r0;
      return f;
   endfunction

   function automatic vec_t mk(
      input logic [6:0][2:0] sym, input logic [6:0] lm, input bit gaps,
      input logic [2:0] e1, input logic [2:0] e2, input logic ez, input logic ee
   );
      vec_t v;
      v.sym = sym; v.last_mask = lm; v.gaps = gaps; v.use_model = 1'b0;
      v.e1 = e1; v.e2 = e2; v.ez = ez; v.ee = ee;
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      e.s1 = v.e1; e.s2 = v.e2; e.z = v.ez; e.e = v.ee;
      exp_q.push_back(e);
      for (int k = 0; k < 7; k++) begin
         if (v.gaps) begin
            repeat ($urandom_range(0, 2)) begin
               bus.in_valid  = 1'b0;
               bus.in_symbol = 3'($urandom_range(0, 7));
               bus.in_last   = 1'($urandom_range(0, 1));
               @(negedge clk);
            end
         end
         checkVal("in_ready_acc", {7'd0, bus.in_ready}, 8'd1);
         bus.in_valid  = 1'b1;
         bus.in_symbol = v.sym[k];
         bus.in_last   = v.last_mask[k];
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_symbol = 3'd0;
   endtask

   task automatic checkOutput(input int hold);
      exp_t e;
      if (exp_q.size() == 0) begin
         checkVal("scoreboard_empty", 8'd0, 8'd1);
         return;
      end
      e = exp_q.pop_front();
      checkVal("syn_valid_latency", {7'd0, bus.syn_valid}, 8'd1);
      checkVal("in_ready_out", {7'd0, bus.in_ready}, 8'd0);
      checkVal("syn1", {5'd0, bus.syn1}, {5'd0, e.s1});
      checkVal("syn2", {5'd0, bus.syn2}, {5'd0, e.s2});
      checkVal("syn_zero", {7'd0, bus.syn_zero}, {7'd0, e.z});
      checkVal("frame_err", {7'd0, bus.frame_err}, {7'd0, e.e});
      for (int h = 0; h < hold; h++) begin
         if (h == 1) begin
            bus.in_valid  = 1'b1;
            bus.in_symbol = 3'd4;
            bus.in_last   = 1'b1;
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
         checkVal("hold_syn_valid", {7'd0, bus.syn_valid}, 8'd1);
         checkVal("hold_in_ready", {7'd0, bus.in_ready}, 8'd0);
         checkVal("hold_syn1", {5'd0, bus.syn1}, {5'd0, e.s1});
         checkVal("hold_syn2", {5'd0, bus.syn2}, {5'd0, e.s2});
      end
      bus.syn_ready = 1'b1;
      @(negedge clk);
      bus.syn_ready = 1'b0;
      checkVal("post_hs_syn_valid", {7'd0, bus.syn_valid}, 8'd0);
      checkVal("post_hs_in_ready", {7'd0, bus.in_ready}, 8'd1);
   endtask

   task automatic checkReset(input string tag);
      checkVal({tag, "_in_ready"}, {7'd0, bus.in_ready}, 8'd1);
      checkVal({tag, "_syn_valid"}, {7'd0, bus.syn_valid}, 8'd0);
      checkVal({tag, "_syn1"}, {5'd0, bus.syn1}, 8'd0);
      checkVal({tag, "_syn2"}, {5'd0, bus.syn2}, 8'd0);
      checkVal({tag, "_syn_zero"}, {7'd0, bus.syn_zero}, 8'd1);
      checkVal({tag, "_frame_err"}, {7'd0, bus.frame_err}, 8'd0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_symbol = 3'd0;
      bus.in_last   = 1'b0;
      bus.syn_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkReset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      tbl[0] = mk(frame7(0, 0, 0, 0, 0, 0, 0), LAST_OK, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
      tbl[1] = mk(frame7(1, 0, 0, 0, 0, 0, 0), LAST_OK, 1'b0, 3'd7, 3'd6, 1'b0, 1'b0);
      tbl[2] = mk(frame7(1, 0, 0, 0, 0, 0, 1), LAST_OK, 1'b0, 3'd3, 3'd5, 1'b0, 1'b0);
      tbl[3] = mk(frame7(1, 0, 0, 0, 0, 0, 1), LAST_OK, 1'b1, 3'd3, 3'd5, 1'b0, 1'b0);
      tbl[4] = mk(frame7(1, 0, 0, 0, 0, 0, 0), 7'b0001000, 1'b0, 3'd7, 3'd6, 1'b0, 1'b1);
      tbl[5] = mk(frame7(1, 0, 0, 0, 0, 0, 1), LAST_OK, 1'b0, 3'd3, 3'd5, 1'b0, 1'b0);
      for (int i = 6; i < 12; i++) begin
         tbl[i].use_model = 1'b1;
         tbl[i].gaps      = (i % 2) == 1;
         for (int k = 0; k < 7; k++) tbl[i].sym[k] = 3'($urandom_range(0, 7));
         if (i == 8) tbl[i].sym = frame7(7, 7, 7, 7, 7, 7, 7);
         tbl[i].last_mask = (i == 9) ? 7'($urandom_range(0, 127)) : LAST_OK;
      end

      foreach (tbl[i]) begin
         if (tbl[i].use_model) begin
            tbl[i].e1 = model_syn(tbl[i].sym, 1);
            tbl[i].e2 = model_syn(tbl[i].sym, 2);
            tbl[i].ez = (tbl[i].e1 == 3'd0) && (tbl[i].e2 == 3'd0);
            tbl[i].ee = tbl[i].last_mask != LAST_OK;
         end
         applyStimulus(tbl[i]);
         checkOutput(0);
      end

      // Backpressure with a stray in_valid pulse, then a frame that would show corruption.
      applyStimulus(tbl[0]);
      checkOutput(5);
      applyStimulus(tbl[1]);
      checkOutput(0);

      // Reset after three accepts discards the partial frame.
      for (int k = 0; k < 3; k++) begin
         bus.in_valid  = 1'b1;
         bus.in_symbol = 3'(5 + k);
         bus.in_last   = 1'b0;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 checkReset("mid_frame_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(tbl[0]);
      checkOutput(0);

      // Reset while holding a result drops it without a handshake.
      applyStimulus(tbl[2]);
      void'(exp_q.pop_front());
      #2 rst_n = 1'b0;
      #1 checkReset("mid_out_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checkVal("no_stale_valid", {7'd0, bus.syn_valid}, 8'd0);
      end
      applyStimulus(tbl[1]);
      checkOutput(0);

      checkVal("scoreboard_drained", 8'(exp_q.size()), 8'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/rs_syndrome_ctrl.md
# rs_syndrome_ctrl

Sequencing controller for the RS(7,5) decoder front end over GF(8). It accepts a 7-symbol received codeword through a valid/ready stream and evaluates the two syndromes S1 = r(α) and S2 = r(α²) by Horner's rule with per-cycle GF multiply-by-constant and GF add. It holds the result behind a valid/ready output handshake until downstream error-location logic takes it. All symbols use the codebase's index form: 0 is the zero element, and value k (1..7) is α^(k-1).

## Interface
Parameters:
- SYMBOL_WIDTH, 3, symbol width in bits.
- N, 7, codeword length and multiplicative group order.

Ports:
- clk  in  1  single clock; everything rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_symbol/in_last valid.
- in_ready  out  1  block can accept a symbol.
- in_symbol  in  SYMBOL_WIDTH  received symbol, index form, highest degree (r6) first.
- in_last  in  1  source marks final symbol of frame.
- syn_valid  out  1  syndromes valid.
- syn_ready  in  1  downstream accepts syndromes.
- syn1  out  SYMBOL_WIDTH  S1, index form.
- syn2  out  SYMBOL_WIDTH  S2, index form.
- syn_zero  out  1  syn1==0 and syn2==0 (no detectable error).
- frame_err  out  1  in_last disagreed with the internal symbol count during this frame.

## Operation
- FSM has 2 states:
  - ACC: in_ready=1, syn_valid=0.
  - OUT: in_ready=0, syn_valid=1.
- Internal registers: cnt (0..6), acc1, acc2 (index form), err flag.
- Accept: in_valid && in_ready at the clock edge. Each accept does:
  - acc1 ← acc1·α ⊕ in_symbol
  - acc2 ← acc2·α² ⊕ in_symbol
  - cnt ← cnt+1
- Multiply by constant α^j (j=1,2), index form: result is 0 if the operand is 0; otherwise ((x−1+j) mod N)+1. Compute the modulo without wrap error at x=7: 7·α → 1; 7·α² → 2; 6·α² → 1.
- Add: convert both operands to power basis, XOR, convert back. Field polynomial is x³+x+1.
  - Power basis table: α⁰=001, α¹=010, α²=100, α³=011, α⁴=110, α⁵=111, α⁶=101; zero=000.
  - The zero element converts to and from 000 in both directions.
- Frame error: err sets on any accept where in_last ≠ (cnt==6). err is sticky within the frame.
- Frame boundary: the frame always ends on the 7th accept, regardless of in_last.
  - On the 7th accept, state → OUT.
  - syn1/syn2 present the final acc1/acc2; frame_err presents err including the 7th check.
- An early in_last does not shorten the frame.
- In OUT: syn_ready=1 at an edge completes the output handshake. On that edge:
  - state → ACC
  - cnt, acc1, acc2, err ← 0
- in_valid while in OUT is ignored; no symbol is consumed.

## Timing
- Reset (rst_n=0, async):
  - state=ACC, cnt=0, acc1=acc2=0, err=0.
  - Outputs: in_ready=1, syn_valid=0, syn1=syn2=0, syn_zero=1, frame_err=0.
- Throughput in ACC: one symbol per cycle. Bubbles on in_valid do not change any register.
- Latency: syn_valid rises in the cycle after the edge that accepts the 7th symbol.
- Output hold: syn1, syn2, syn_zero and frame_err are registered, stable for all of OUT, and change only at reset or at the end of a frame.
- in_ready returns to 1 in the cycle after the syn handshake edge. Minimum frame period is 8 cycles.
- syn_valid does not depend combinationally on syn_ready. in_ready does not depend combinationally on in_valid.
- Reset mid-frame or mid-OUT: the partial frame is discarded and there is no output for it.

## Test plan
- All-zero codeword, 7 back-to-back accepts, in_last on the 7th, syn_ready=1 → syn_valid in cycle 8; syn1=0, syn2=0, syn_zero=1, frame_err=0.
- r6=1 (α⁰), then six zeros → syn1=7 (α⁶), syn2=6 (α⁵), syn_zero=0.
- r6=1 and r0=1, other symbols zero → syn1=3 (α²), syn2=5 (α⁴). Repeat with random in_valid gaps: identical result.
- Backpressure: hold syn_ready=0 for 5 cycles after syn_valid rises. Required:
  - Outputs stay stable and in_ready stays 0.
  - An in_valid pulse in this window is not consumed.
  - After the handshake, the next frame is correct.
- in_last asserted on the 4th symbol and absent on the 7th → frame still ends after 7 accepts; frame_err=1. The following clean frame reports frame_err=0.
- Assert rst_n=0 after 3 accepts → all outputs take reset values. A fresh all-zero frame afterwards → syn1=syn2=0 with no stale accumulator contribution.
